// File: rtl/shadow_spill_unit.sv
// Spill/fill engine for the shadow register bank: streams the 16 shadow words
// to the stack after a shadow save, and reloads them before a trap return.
module shadow_spill_unit #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 4,
  parameter int NUM_WORDS_SHADOW = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spill_valid_i,
  input  logic                  fill_valid_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] shadow_sp_i,
  output logic [ADDR_WIDTH-1:0] shadow_raddr_o,
  input  logic [DATA_WIDTH-1:0] shadow_rdata_i,
  output logic [ADDR_WIDTH-1:0] shadow_waddr_o,
  output logic [DATA_WIDTH-1:0] shadow_wdata_o,
  output logic                  shadow_we_o,
  output logic                  shadow_load_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SPILL     = 3'd1;
  localparam logic [2:0] FILL_REQ  = 3'd2;
  localparam logic [2:0] FILL_WAIT = 3'd3;
  localparam logic [2:0] LOAD      = 3'd4;

  localparam int                  BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD    = ADDR_WIDTH'(NUM_WORDS_SHADOW - 1);

  logic [2:0]            state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic [DATA_WIDTH-1:0] base, base_next;
  logic                  done, done_next;
  logic [DATA_WIDTH-1:0] word_addr;

  // Spill wins over fill; an unaccepted fill must be held by its requester.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    base_next  = base;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (spill_valid_i) begin
          base_next  = shadow_sp_i;
          cnt_next   = '0;
          state_next = SPILL;
        end else if (fill_valid_i) begin
          base_next  = shadow_sp_i;
          cnt_next   = '0;
          state_next = FILL_REQ;
        end
      end
      SPILL: begin
        if (mem_gnt_i) begin
          cnt_next = cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_WORD) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      FILL_REQ: begin
        if (mem_gnt_i) begin
          state_next = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_rvalid_i) begin
          if (cnt == LAST_WORD) begin
            state_next = LOAD;
          end else begin
            cnt_next   = cnt + ADDR_WIDTH'(1);
            state_next = FILL_REQ;
          end
        end
      end
      LOAD: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      base  <= base_next;
      done  <= done_next;
    end
  end

  // Address wraps modulo 2**DATA_WIDTH by construction of the adder width.
  assign word_addr = base + (DATA_WIDTH'(cnt) * DATA_WIDTH'(BYTES_PER_WORD));

  assign ready_o        = (state == IDLE);
  assign busy_o         = ~ready_o;
  assign done_o         = done;

  assign mem_req_o      = (state == SPILL) || (state == FILL_REQ);
  assign mem_we_o       = (state == SPILL);
  assign mem_addr_o     = mem_req_o ? word_addr : '0;
  assign mem_wdata_o    = mem_we_o ? shadow_rdata_i : '0;

  assign shadow_raddr_o = cnt;
  assign shadow_we_o    = (state == FILL_WAIT) && mem_rvalid_i;
  assign shadow_waddr_o = cnt;
  assign shadow_wdata_o = shadow_we_o ? mem_rdata_i : '0;
  assign shadow_load_o  = (state == LOAD);

endmodule

// File: tb/tb_shadow_spill_unit.sv
// Self-checking bench for shadow_spill_unit: a transaction-queue model of the
// expected stores, loads and shadow writes, plus a memory responder.
module tb_shadow_spill_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spill_valid_i, fill_valid_i;
  logic        ready_o, busy_o, done_o;
  logic [63:0] shadow_sp_i;
  logic [3:0]  shadow_raddr_o, shadow_waddr_o;
  logic [63:0] shadow_rdata_i, shadow_wdata_o;
  logic        shadow_we_o, shadow_load_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  shadow_spill_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_WORDS_SHADOW(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .spill_valid_i(spill_valid_i), .fill_valid_i(fill_valid_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .shadow_sp_i(shadow_sp_i),
    .shadow_raddr_o(shadow_raddr_o), .shadow_rdata_i(shadow_rdata_i),
    .shadow_waddr_o(shadow_waddr_o), .shadow_wdata_o(shadow_wdata_o),
    .shadow_we_o(shadow_we_o), .shadow_load_o(shadow_load_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] shadow_bank [16];
  assign shadow_rdata_i = shadow_bank[shadow_raddr_o];

  logic [63:0] mem_model [logic [63:0]];

  function automatic logic [63:0] memRead(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a;
  endfunction

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Memory responder knobs
  int gnt_delay = 0;
  int rv_delay  = 1;
  bit stray_rvalid = 1'b0;

  initial begin : responder
    logic        p_req, p_gnt, p_we;
    logic [63:0] p_addr, pend_addr;
    bit          pend;
    int          wait_left, age;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    pend = 1'b0; age = 0; wait_left = 0; pend_addr = '0;
    forever begin
      @(negedge clk_i);
      p_req = mem_req_o; p_gnt = mem_gnt_i; p_we = mem_we_o; p_addr = mem_addr_o;
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        pend = 1'b0; age = 0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      end else begin
        if (p_req && p_gnt && !p_we) begin
          pend = 1'b1; wait_left = rv_delay - 1; pend_addr = p_addr;
        end
        if (pend) begin
          if (wait_left == 0) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = memRead(pend_addr); pend = 1'b0;
          end else begin
            wait_left--; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
          end
        end else begin
          mem_rvalid_i = stray_rvalid;
          mem_rdata_i  = stray_rvalid ? 64'hDEAD_BEEF : 64'h0;
        end
        if (mem_req_o) begin
          if (p_req && !p_gnt) age++;
          else age = 0;
        end else begin
          age = 0;
        end
        mem_gnt_i = mem_req_o && (age >= gnt_delay);
      end
    end
  end

  // Model state: queues of expected memory ops and shadow writes per operation
  typedef struct packed { logic we; logic [63:0] addr; logic [63:0] data; } mem_op_t;
  typedef struct packed { logic [3:0] waddr; logic [63:0] data; } sw_t;
  mem_op_t exp_mem [$];
  sw_t     exp_sw  [$];
  bit op_active = 0, op_is_fill = 0, load_out = 0, load_phase = 0, done_exp = 0;
  int cyc = 0, accept_cyc = 0;

  // Observation logs used by the literal pins
  int accept_count = 0, done_count = 0, done_delay = 0, load_count = 0;
  int store_count = 0, sw_count = 0, load_at_sw = 0;
  bit load_logged = 0;
  logic [63:0] first_load_addr;
  logic [63:0] store_addr_log [16];
  logic [63:0] store_data_log [16];
  logic [63:0] sw_addr_log [16];
  logic [63:0] sw_data_log [16];

  initial begin : monitor
    bit was_idle, exp_req, exp_swe;
    mem_op_t op;
    sw_t sw;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        checkOutput("rst_ready", 64'(ready_o), 64'd1);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_shadow_we", 64'(shadow_we_o), 64'd0);
        checkOutput("rst_shadow_load", 64'(shadow_load_o), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we_o), 64'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 64'd0);
        checkOutput("rst_shadow_raddr", 64'(shadow_raddr_o), 64'd0);
        checkOutput("rst_shadow_waddr", 64'(shadow_waddr_o), 64'd0);
        checkOutput("rst_shadow_wdata", shadow_wdata_o, 64'd0);
        if (shadow_load_o) load_count++;
        op_active = 0; load_out = 0; load_phase = 0; done_exp = 0;
        exp_mem.delete(); exp_sw.delete();
      end else begin
        was_idle = !op_active;
        exp_req  = op_active && !load_phase && !load_out && (exp_mem.size() > 0);
        exp_swe  = op_active && op_is_fill && load_out && mem_rvalid_i;
        checkOutput("ready", 64'(ready_o), 64'(!op_active));
        checkOutput("busy", 64'(busy_o), 64'(op_active));
        checkOutput("done", 64'(done_o), 64'(done_exp));
        if (done_o) begin done_count++; done_delay = cyc - accept_cyc; end
        done_exp = 0;
        checkOutput("mem_req", 64'(mem_req_o), 64'(exp_req));
        if (exp_req) begin
          checkOutput("mem_we", 64'(mem_we_o), 64'(exp_mem[0].we));
          checkOutput("mem_addr", mem_addr_o, exp_mem[0].addr);
          if (exp_mem[0].we) checkOutput("mem_wdata", mem_wdata_o, exp_mem[0].data);
        end
        checkOutput("shadow_we", 64'(shadow_we_o), 64'(exp_swe));
        if (exp_swe && exp_sw.size() > 0) begin
          checkOutput("shadow_waddr", 64'(shadow_waddr_o), 64'(exp_sw[0].waddr));
          checkOutput("shadow_wdata", shadow_wdata_o, exp_sw[0].data);
        end
        checkOutput("shadow_load", 64'(shadow_load_o), 64'(load_phase));

        if (mem_req_o && mem_gnt_i && mem_we_o && store_count < 16) begin
          store_addr_log[store_count] = mem_addr_o;
          store_data_log[store_count] = mem_wdata_o;
          store_count++;
        end
        if (mem_req_o && mem_gnt_i && !mem_we_o && !load_logged) begin
          first_load_addr = mem_addr_o; load_logged = 1;
        end
        if (shadow_we_o && sw_count < 16) begin
          sw_addr_log[sw_count] = 64'(shadow_waddr_o);
          sw_data_log[sw_count] = shadow_wdata_o;
          sw_count++;
        end
        if (shadow_load_o) begin load_count++; load_at_sw = sw_count; end

        if (was_idle) begin
          if (spill_valid_i || fill_valid_i) begin
            op_is_fill = !spill_valid_i;
            for (int i = 0; i < 16; i++) begin
              op.we   = !op_is_fill;
              op.addr = shadow_sp_i + 64'(i * 8);
              op.data = op_is_fill ? 64'h0 : shadow_bank[i];
              exp_mem.push_back(op);
              if (op_is_fill) begin
                sw.waddr = 4'(i);
                sw.data  = memRead(op.addr);
                exp_sw.push_back(sw);
              end
            end
            op_active = 1; accept_cyc = cyc; accept_count++;
            store_count = 0; sw_count = 0; load_logged = 0;
          end
        end else if (load_phase) begin
          load_phase = 0; op_active = 0; done_exp = 1;
        end else if (exp_req && mem_gnt_i) begin
          if (!exp_mem[0].we) load_out = 1;
          void'(exp_mem.pop_front());
          if (!op_is_fill && exp_mem.size() == 0) begin op_active = 0; done_exp = 1; end
        end else if (exp_swe) begin
          load_out = 0;
          if (exp_sw.size() > 0) void'(exp_sw.pop_front());
          if (exp_sw.size() == 0) load_phase = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input bit spill, input bit fill, input logic [63:0] sp);
    spill_valid_i = spill;
    fill_valid_i  = fill;
    shadow_sp_i   = sp;
  endtask

  task automatic stepCycle();
    @(posedge clk_i); #1;
  endtask

  task automatic waitAccept(input int budget, input string name);
    int start;
    start = accept_count;
    for (int i = 0; i < budget; i++) begin
      stepCycle();
      if (accept_count != start) return;
    end
    checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic waitDone(input int budget, input string name);
    int start;
    start = done_count;
    for (int i = 0; i < budget; i++) begin
      stepCycle();
      if (done_count != start) return;
    end
    checkOutput({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic preload(input logic [63:0] base);
    for (int i = 0; i < 16; i++) mem_model[base + 64'(i * 8)] = 64'hA0 + 64'(i);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lc0, a0, spill_acc;
    for (int i = 0; i < 16; i++) shadow_bank[i] = 64'h1000 + 64'(i);
    applyStimulus(0, 0, 64'h0);
    repeat (3) stepCycle();
    rst_ni = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] spill with grant tied high and stray rvalid");
    gnt_delay = 0; rv_delay = 1; stray_rvalid = 1;
    applyStimulus(1, 0, 64'h8000_0F80);
    waitAccept(5, "spill");
    applyStimulus(0, 0, 64'h0);
    waitDone(40, "spill");
    stray_rvalid = 0;
    checkOutput("spill_done_cycle", 64'(done_delay), 64'd17);
    checkOutput("spill_store_count", 64'(store_count), 64'd16);
    checkOutput("spill_addr0", store_addr_log[0], 64'h8000_0F80);
    checkOutput("spill_addr15", store_addr_log[15], 64'h8000_0FF8);
    checkOutput("spill_data15", store_data_log[15], 64'h100F);
    checkOutput("spill_no_shadow_we", 64'(sw_count), 64'd0);

    $display("[TB] fill with delayed grant and rvalid");
    gnt_delay = 2; rv_delay = 3;
    preload(64'h9000);
    lc0 = load_count;
    applyStimulus(0, 1, 64'h9000);
    waitAccept(5, "fill_slow");
    applyStimulus(0, 0, 64'h0);
    waitDone(200, "fill_slow");
    checkOutput("fill_slow_done_cycle", 64'(done_delay), 64'd98);
    checkOutput("fill_slow_writes", 64'(sw_count), 64'd16);
    checkOutput("fill_slow_loads", 64'(load_count - lc0), 64'd1);
    checkOutput("fill_slow_load_after", 64'(load_at_sw), 64'd16);
    checkOutput("fill_slow_data0", sw_data_log[0], 64'hA0);
    checkOutput("fill_slow_addr15", sw_addr_log[15], 64'd15);
    checkOutput("fill_slow_data15", sw_data_log[15], 64'hAF);

    $display("[TB] spill and fill requested together");
    gnt_delay = 0; rv_delay = 1;
    applyStimulus(1, 1, 64'h4000);
    waitAccept(5, "both_spill");
    spill_acc = accept_cyc;
    applyStimulus(0, 1, 64'h6000);
    waitAccept(40, "both_fill");
    applyStimulus(0, 0, 64'h0);
    checkOutput("both_fill_accept_offset", 64'(accept_cyc - spill_acc), 64'd17);
    waitDone(100, "both_fill");
    checkOutput("both_fill_done_cycle", 64'(done_delay), 64'd34);
    checkOutput("both_fill_first_addr", first_load_addr, 64'h6000);

    $display("[TB] address wrap-around");
    applyStimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFF8);
    waitAccept(5, "wrap");
    applyStimulus(0, 0, 64'h0);
    waitDone(40, "wrap");
    checkOutput("wrap_addr0", store_addr_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("wrap_addr1", store_addr_log[1], 64'h0);
    checkOutput("wrap_addr15", store_addr_log[15], 64'h70);

    $display("[TB] reset in the middle of a fill");
    preload(64'h7000);
    lc0 = load_count;
    applyStimulus(0, 1, 64'h7000);
    waitAccept(5, "rst_fill");
    applyStimulus(0, 0, 64'h0);
    for (int i = 0; i < 40 && sw_count < 5; i++) stepCycle();
    checkOutput("rst_fill_words_before", 64'(sw_count), 64'd5);
    #1 rst_ni = 1'b0;
    repeat (2) stepCycle();
    checkOutput("rst_fill_no_load", 64'(load_count - lc0), 64'd0);
    rst_ni = 1'b1;
    stepCycle();
    applyStimulus(0, 1, 64'h7000);
    waitAccept(5, "refill");
    applyStimulus(0, 0, 64'h0);
    waitDone(100, "refill");
    checkOutput("refill_addr0", sw_addr_log[0], 64'd0);
    checkOutput("refill_data0", sw_data_log[0], 64'hA0);
    checkOutput("refill_writes", 64'(sw_count), 64'd16);
    checkOutput("refill_loads", 64'(load_count - lc0), 64'd1);

    $display("[TB] spill request while a fill is busy");
    applyStimulus(0, 1, 64'h9000);
    waitAccept(5, "busy_fill");
    applyStimulus(0, 0, 64'h0);
    a0 = accept_count;
    repeat (3) stepCycle();
    applyStimulus(1, 0, 64'h1234);
    stepCycle();
    checkOutput("busy_ready_low", 64'(ready_o), 64'd0);
    applyStimulus(0, 0, 64'h0);
    waitDone(100, "busy_fill");
    checkOutput("busy_no_accept", 64'(accept_count - a0), 64'd0);
    checkOutput("busy_fill_done_cycle", 64'(done_delay), 64'd34);
    checkOutput("busy_fill_writes", 64'(sw_count), 64'd16);
    checkOutput("busy_fill_data15", sw_data_log[15], 64'hAF);

    repeat (3) stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
